average_sliding: RTL and testbench

- Moving-average (boxcar) filter over the most recent 2^window_log2 samples of an unsigned stream.
- Takes one sample on every rising edge of `trigger`.
- Keeps a running sum: add the newest sample, subtract the sample leaving the window.
- Sits after ADC/sensor sample paths to smooth readings before thresholding or display.

---
 rtl/average_sliding.sv | 56 +++++
 tb/tb_average_sliding.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/average_sliding.sv
// Boxcar moving-average filter over the last 2^window_log2 unsigned samples.
// A running sum is kept: each trigger edge adds the new sample and removes the
// sample that falls out of the window. The output is the sum shifted down.
module average_sliding #(
  parameter int unsigned bitwidth_sample           = 12,
  parameter int unsigned window_log2               = 3,
  parameter int unsigned initial_accumulator_value = 0
) (
  input  logic                       trigger,
  input  logic                       reset,
  input  logic [bitwidth_sample-1:0] sample_value,
  output logic [bitwidth_sample-1:0] averaged_value
);

  localparam int unsigned n     = 1 << window_log2;
  localparam int unsigned acc_w = bitwidth_sample + window_log2;

  // Preload value per entry; the parameter's low bits are dropped so that the
  // sum always equals the sum of the buffer entries.
  localparam logic [acc_w-1:0]           init_acc_full = acc_w'(initial_accumulator_value);
  localparam logic [bitwidth_sample-1:0] preload       = init_acc_full[acc_w-1:window_log2];
  localparam logic [acc_w-1:0]           preload_acc   = {preload, {window_log2{1'b0}}};

  logic [bitwidth_sample-1:0] buf_q [n];
  logic [window_log2-1:0]     ptr_q, ptr_d;
  logic [acc_w-1:0]           acc_q, acc_d;
  logic [bitwidth_sample-1:0] old_sample;

  // Next-state: swap the oldest sample for the newest in the running sum.
  // old_sample is always a component of acc_q, so the difference never underflows.
  always_comb begin
    old_sample = buf_q[ptr_q];
    acc_d      = acc_q + acc_w'(sample_value) - acc_w'(old_sample);
    // Window length is a power of two, so the pointer wraps naturally.
    ptr_d      = ptr_q + 1'b1;
  end

  // State: sample history, write pointer and running sum.
  always_ff @(posedge trigger or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < n; i++) begin
        buf_q[i] <= preload;
      end
      ptr_q <= '0;
      acc_q <= preload_acc;
    end else begin
      buf_q[ptr_q] <= sample_value;
      ptr_q        <= ptr_d;
      acc_q        <= acc_d;
    end
  end

  // Output: truncating divide by the window length.
  assign averaged_value = acc_q[acc_w-1:window_log2];

endmodule

// File: tb/tb_average_sliding.sv
// Bench for average_sliding: queue-based window model checked every cycle,
// plus hand-computed literal expectations from the directed scenarios.
module tb_average_sliding;

  localparam int unsigned N = 8;

  logic        trigger;
  logic        reset;
  logic [11:0] sample_value;
  logic [11:0] sample_pre;
  logic [11:0] avg_def, avg_800, avg_803;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          model_on = 1'b0;

  int unsigned q_def [$];
  int unsigned q_800 [$];
  int unsigned q_803 [$];

  average_sliding dut (
    .trigger       (trigger),
    .reset         (reset),
    .sample_value  (sample_value),
    .averaged_value(avg_def)
  );

  average_sliding #(.initial_accumulator_value(800)) dut_800 (
    .trigger       (trigger),
    .reset         (reset),
    .sample_value  (sample_pre),
    .averaged_value(avg_800)
  );

  average_sliding #(.initial_accumulator_value(803)) dut_803 (
    .trigger       (trigger),
    .reset         (reset),
    .sample_value  (sample_pre),
    .averaged_value(avg_803)
  );

  initial trigger = 1'b0;
  always #5 trigger = ~trigger;

  function automatic int unsigned window_avg(input int unsigned q [$]);
    int unsigned sum = 0;
    foreach (q[i]) sum += q[i];
    return sum / N;
  endfunction

  task automatic model_reset();
    q_def = {};
    q_800 = {};
    q_803 = {};
    for (int i = 0; i < N; i++) begin
      q_def.push_back(0);
      q_800.push_back(800 / N);
      q_803.push_back(803 / N);
    end
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the window is simply the last N samples seen while reset is high.
  always @(posedge trigger or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      q_def.push_back(sample_value);
      void'(q_def.pop_front());
      q_800.push_back(sample_pre);
      void'(q_800.pop_front());
      q_803.push_back(sample_pre);
      void'(q_803.pop_front());
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge trigger) begin
    if (model_on) begin
      check("model_def", avg_def, window_avg(q_def));
      check("model_800", avg_800, window_avg(q_800));
      check("model_803", avg_803, window_avg(q_803));
    end
  end

  task automatic step(input logic [11:0] s);
    sample_value = s;
    @(posedge trigger);
    @(negedge trigger);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset        = 1'b0;
    sample_value = '0;
    sample_pre   = 12'd100;
    @(negedge trigger);
    @(negedge trigger);
    check("reset_def", avg_def, 0);
    check("reset_800", avg_800, 100);
    check("reset_803", avg_803, 100);
    check("reset_acc", dut.acc_q, 0);
    reset    = 1'b1;
    model_on = 1'b1;

    // Ramp up with constant 256.
    for (int i = 1; i <= 8; i++) begin
      step(12'd256);
      check("ramp_up", avg_def, 32 * i);
    end
    for (int i = 0; i < 3; i++) begin
      step(12'd256);
      check("hold_256", avg_def, 256);
    end
    check("preload_hold_800", avg_800, 100);
    check("preload_hold_803", avg_803, 100);

    // Step down to 0.
    for (int i = 1; i <= 8; i++) begin
      step(12'd0);
      check("step_down", avg_def, 256 - 32 * i);
    end
    step(12'd0);
    check("hold_0", avg_def, 0);

    // Full scale, then back to 0.
    for (int i = 0; i < 10; i++) step(12'd4095);
    check("full_scale", avg_def, 4095);
    check("full_acc", dut.acc_q, 32760);
    for (int i = 0; i < 8; i++) step(12'd0);
    check("full_to_0", avg_def, 0);

    // Truncation: a lone 1 in the window never shows.
    for (int i = 0; i < 24; i++) begin
      step((i % 8 == 0) ? 12'd1 : 12'd0);
      check("trunc", avg_def, 0);
    end
    check("trunc_acc", dut.acc_q, 1);

    // Flush, then reset mid-stream at output 160.
    for (int i = 0; i < 8; i++) step(12'd0);
    for (int i = 0; i < 5; i++) step(12'd256);
    check("pre_reset_160", avg_def, 160);
    sample_pre = 12'd37;
    #2 reset = 1'b0;
    #1;
    check("async_reset_def", avg_def, 0);
    check("async_reset_800", avg_800, 100);
    #1 reset = 1'b1;
    step(12'd256);
    check("rerampe_32", avg_def, 32);
    step(12'd256);
    check("rerampe_64", avg_def, 64);

    // Incrementing ramp across several pointer wraps; model checks each cycle.
    for (int i = 0; i < 24; i++) begin
      sample_pre = 12'(i * 97 + 5);
      step(12'(i * 150 + 3));
    end
    // Last 8 samples: i=16..23 -> sum = 150*(16+..+23)+24 = 150*156+24 = 23424 -> 2928.
    check("ramp_literal", avg_def, 2928);

    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
